// File: rtl/vga_pixel_fetch_if.sv
// Pixel-fetch bus bundle: display-side pixel handshake plus the VRAM read port.
// "slave" is the fetch block itself, "master" is the surrounding environment.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16
) ();
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              frame_start;
  logic              pix_req;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              vram_rd_en;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_rd_valid;
  logic [DATA_W-1:0] vram_rd_data;
  logic              underflow;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  frame_start, pix_req, vram_rd_valid, vram_rd_data,
    output pix_data, pix_valid, vram_rd_en, vram_addr, underflow, fifo_level
  );
  modport master (
    output frame_start, pix_req, vram_rd_valid, vram_rd_data,
    input  pix_data, pix_valid, vram_rd_en, vram_addr, underflow, fifo_level
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Raster-order VRAM prefetcher: credit-limited reads into a small pixel FIFO,
// one registered pixel per pix_req, with in-flight returns dropped across frame_start.
module vga_pixel_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12
) (
  input logic             clk,
  input logic             rst,
  vga_pixel_fetch_if.slave bus
);
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Back-to-back frame_starts can stack up stale returns beyond DEPTH.
  localparam int DSC_W = LVL_W + 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [LVL_W:0]    DEPTH_C   = (LVL_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr;
  logic [LVL_W-1:0]    count, outstanding;
  logic [DSC_W-1:0]    discard, inflight, inflight_nx;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   pix_data_q;
  logic                pix_valid_q, underflow_q;
  logic                rd_en, push, pop;

  always_comb begin
    rd_en    = 1'b0;
    state_nx = state;
    if (state == FETCH && !bus.frame_start)
      rd_en = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
    if (bus.frame_start)
      state_nx = FETCH;
    else if (rd_en && addr == LAST_ADDR)
      state_nx = DONE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // Returns with no matching request (e.g. after reset) fall through unused.
  assign push = bus.vram_rd_valid && discard == '0 && outstanding != '0 && !bus.frame_start;
  assign pop  = bus.pix_req && count != '0 && !bus.frame_start;

  // Everything still in flight at frame_start must be swallowed; a return
  // landing in that same cycle already accounts for one of them.
  always_comb begin
    inflight    = discard + DSC_W'(outstanding);
    inflight_nx = inflight - DSC_W'(bus.vram_rd_valid && inflight != '0);
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.vram_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.frame_start) begin
      addr        <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= inflight_nx;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (rd_en && addr != LAST_ADDR) addr <= addr + 1'b1;
      outstanding <= outstanding + LVL_W'(rd_en) - LVL_W'(push);
      if (bus.vram_rd_valid && discard != '0) discard <= discard - 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LVL_W'(push) - LVL_W'(pop);
      if (bus.pix_req) begin
        if (count != '0) begin
          pix_data_q  <= mem[rd_ptr];
          pix_valid_q <= 1'b1;
        end else begin
          pix_data_q  <= '0;
          pix_valid_q <= 1'b0;
          underflow_q <= 1'b1;
        end
      end else begin
        pix_valid_q <= 1'b0;
      end
    end
  end

  assign bus.vram_rd_en = rd_en;
  assign bus.vram_addr  = addr;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.underflow  = underflow_q;
  assign bus.fifo_level = count;
endmodule
